instruction_prefetch: RTL and testbench

- Writer side of the instruction byte FIFO that the decode stages (ModRM, immediate and opcode readers) consume.
- Forms the physical fetch address from CS:IP and issues 16-bit word reads on the instruction memory port.
- Pushes the returned bytes into the FIFO one per cycle, honouring FIFO full.
- On a branch (load_new_ip) it flushes the FIFO and restarts fetch, discarding any read already in flight.

---
 rtl/instruction_prefetch_pkg.sv | 28 ++
 rtl/instruction_prefetch_if.sv | 35 +++
 rtl/instruction_prefetch_byte_buffer.sv | 54 +++++
 rtl/instruction_prefetch.sv | 121 ++++++++++++
 tb/tb_instruction_prefetch.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/instruction_prefetch_pkg.sv
// Shared prefetch types, reset defaults and segment:offset address helpers.
package instruction_prefetch_pkg;

    typedef enum logic [1:0] {
        PF_IDLE  = 2'd0,
        PF_FETCH = 2'd1,
        PF_DRAIN = 2'd2
    } prefetch_state_e;

    localparam logic [15:0] DEF_RESET_CS = 16'hffff;
    localparam logic [15:0] DEF_RESET_IP = 16'h0000;

    // Real-mode physical address, wraps modulo 1 MiB.
    function automatic logic [19:0] phys_addr(
        input logic [15:0] cs,
        input logic [15:0] ip
    );
        return {cs, 4'b0000} + {4'b0000, ip};
    endfunction

    function automatic logic [18:0] word_addr(
        input logic [15:0] cs,
        input logic [15:0] ip
    );
        return 19'(phys_addr(cs, ip) >> 1);
    endfunction

endpackage

// File: rtl/instruction_prefetch_if.sv
// Instruction memory read port and byte FIFO write port of the prefetcher.
interface instruction_prefetch_if;

    logic        mem_access;
    logic        mem_ack;
    logic [18:0] mem_address;
    logic [15:0] mem_data;
    logic        fifo_wr_en;
    logic [7:0]  fifo_wr_data;
    logic        fifo_full;
    logic        fifo_reset;

    modport master (
        output mem_access,
        output mem_address,
        input  mem_ack,
        input  mem_data,
        output fifo_wr_en,
        output fifo_wr_data,
        output fifo_reset,
        input  fifo_full
    );

    modport slave (
        input  mem_access,
        input  mem_address,
        output mem_ack,
        output mem_data,
        input  fifo_wr_en,
        input  fifo_wr_data,
        input  fifo_reset,
        output fifo_full
    );

endinterface

// File: rtl/instruction_prefetch_byte_buffer.sv
// Holds one fetched word and hands its bytes out one at a time.
module instruction_prefetch_byte_buffer (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        clear,
    input  logic [15:0] word_in,
    input  logic        start_hi,
    input  logic [1:0]  count,
    input  logic        advance,
    output logic [7:0]  byte_out,
    output logic        empty,
    output logic        last
);

    logic [15:0] word_q, word_d;
    logic        hi_q, hi_d;
    logic [1:0]  cnt_q, cnt_d;

    always_comb begin
        word_d = word_q;
        hi_d   = hi_q;
        cnt_d  = cnt_q;
        if (clear) begin
            word_d = 16'h0000;
            hi_d   = 1'b0;
            cnt_d  = 2'd0;
        end else if (load) begin
            word_d = word_in;
            hi_d   = start_hi;
            cnt_d  = count;
        end else if (advance && cnt_q != 2'd0) begin
            hi_d  = 1'b1;
            cnt_d = cnt_q - 2'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word_q <= 16'h0000;
            hi_q   <= 1'b0;
            cnt_q  <= 2'd0;
        end else begin
            word_q <= word_d;
            hi_q   <= hi_d;
            cnt_q  <= cnt_d;
        end
    end

    assign byte_out = hi_q ? word_q[15:8] : word_q[7:0];
    assign empty    = (cnt_q == 2'd0);
    assign last     = (cnt_q == 2'd1);

endmodule

// File: rtl/instruction_prefetch.sv
// Instruction prefetcher: fetches words at CS:IP and feeds the decode byte FIFO.
module instruction_prefetch
    import instruction_prefetch_pkg::*;
#(
    parameter logic [15:0] RESET_CS = DEF_RESET_CS,
    parameter logic [15:0] RESET_IP = DEF_RESET_IP
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load_new_ip,
    input  logic [15:0]           new_cs,
    input  logic [15:0]           new_ip,
    instruction_prefetch_if.master bus
);

    localparam logic [18:0] RESET_WADDR = word_addr(RESET_CS, RESET_IP);

    prefetch_state_e state_q, state_d;
    logic [15:0]     fetch_cs_q, fetch_cs_d;
    logic [15:0]     fetch_ip_q, fetch_ip_d;
    logic            discard_q, discard_d;
    logic [18:0]     req_addr_q, req_addr_d;

    logic       buf_load;
    logic       buf_clear;
    logic       buf_empty;
    logic       buf_last;
    logic [7:0] buf_byte;
    logic       wr_en;

    assign wr_en = (state_q == PF_DRAIN) && !buf_empty &&
                   !bus.fifo_full && !load_new_ip;

    instruction_prefetch_byte_buffer u_buf (
        .clk      (clk),
        .reset    (reset),
        .load     (buf_load),
        .clear    (buf_clear),
        .word_in  (bus.mem_data),
        .start_hi (fetch_ip_q[0]),
        .count    (fetch_ip_q[0] ? 2'd1 : 2'd2),
        .advance  (wr_en),
        .byte_out (buf_byte),
        .empty    (buf_empty),
        .last     (buf_last)
    );

    always_comb begin
        state_d    = state_q;
        fetch_cs_d = fetch_cs_q;
        fetch_ip_d = fetch_ip_q;
        discard_d  = discard_q;
        req_addr_d = req_addr_q;
        buf_load   = 1'b0;
        buf_clear  = 1'b0;
        if (load_new_ip) begin
            fetch_cs_d = new_cs;
            fetch_ip_d = new_ip;
            buf_clear  = 1'b1;
            // A bus cycle in flight cannot be aborted; wait out its ack.
            if (state_q == PF_FETCH && !bus.mem_ack) begin
                discard_d = 1'b1;
                state_d   = PF_FETCH;
            end else begin
                discard_d = 1'b0;
                state_d   = PF_IDLE;
            end
        end else begin
            unique case (state_q)
                PF_IDLE: begin
                    if (!bus.fifo_full) begin
                        state_d    = PF_FETCH;
                        req_addr_d = word_addr(fetch_cs_q, fetch_ip_q);
                    end
                end
                PF_FETCH: begin
                    if (bus.mem_ack) begin
                        if (discard_q) begin
                            discard_d = 1'b0;
                            state_d   = PF_IDLE;
                        end else begin
                            buf_load   = 1'b1;
                            fetch_ip_d = fetch_ip_q +
                                (fetch_ip_q[0] ? 16'd1 : 16'd2);
                            state_d    = PF_DRAIN;
                        end
                    end
                end
                PF_DRAIN: begin
                    if (buf_empty || (wr_en && buf_last)) begin
                        state_d = PF_IDLE;
                    end
                end
                default: state_d = PF_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= PF_IDLE;
            fetch_cs_q <= RESET_CS;
            fetch_ip_q <= RESET_IP;
            discard_q  <= 1'b0;
            req_addr_q <= RESET_WADDR;
        end else begin
            state_q    <= state_d;
            fetch_cs_q <= fetch_cs_d;
            fetch_ip_q <= fetch_ip_d;
            discard_q  <= discard_d;
            req_addr_q <= req_addr_d;
        end
    end

    assign bus.mem_access   = (state_q == PF_FETCH);
    assign bus.mem_address  = req_addr_q;
    assign bus.fifo_wr_en   = wr_en;
    assign bus.fifo_wr_data = buf_byte;
    assign bus.fifo_reset   = load_new_ip;

endmodule

// File: tb/tb_instruction_prefetch.sv
// Directed bench for instruction_prefetch with immediate-assertion checks.
module tb_instruction_prefetch;

    logic        clk;
    logic        reset;
    logic        load_new_ip;
    logic [15:0] new_cs;
    logic [15:0] new_ip;

    int tests;
    int fails;
    logic [7:0] pushes[$];

    instruction_prefetch_if bus_if ();

    instruction_prefetch #(
        .RESET_CS (16'hffff),
        .RESET_IP (16'h0000)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .load_new_ip (load_new_ip),
        .new_cs      (new_cs),
        .new_ip      (new_ip),
        .bus         (bus_if.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!reset && bus_if.fifo_wr_en)
            pushes.push_back(bus_if.fifo_wr_data);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic ack(input logic [15:0] data);
        bus_if.mem_ack  = 1'b1;
        bus_if.mem_data = data;
        tick();
        bus_if.mem_ack  = 1'b0;
        bus_if.mem_data = 16'h0000;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b1;
        load_new_ip = 1'b0;
        new_cs = 16'h0000;
        new_ip = 16'h0000;
        bus_if.mem_ack = 1'b0;
        bus_if.mem_data = 16'h0000;
        bus_if.fifo_full = 1'b0;
        #2;
        chk("rst_access", 32'(bus_if.mem_access), 0);
        chk("rst_wr_en", 32'(bus_if.fifo_wr_en), 0);
        chk("rst_freset", 32'(bus_if.fifo_reset), 0);
        chk("rst_wdata", 32'(bus_if.fifo_wr_data), 0);
        chk("rst_addr", 32'(bus_if.mem_address), 32'h7fff8);
        tick();
        tick();
        reset = 1'b0;

        // Reset fetch: word 3412 at FFFF0
        tick();
        chk("t1_access", 32'(bus_if.mem_access), 1);
        chk("t1_addr", 32'(bus_if.mem_address), 32'h7fff8);
        tick();
        chk("t1_addr_hold", 32'(bus_if.mem_address), 32'h7fff8);
        ack(16'h3412);
        chk("t1_wr0_en", 32'(bus_if.fifo_wr_en), 1);
        chk("t1_wr0_data", 32'(bus_if.fifo_wr_data), 32'h12);
        tick();
        chk("t1_wr1_en", 32'(bus_if.fifo_wr_en), 1);
        chk("t1_wr1_data", 32'(bus_if.fifo_wr_data), 32'h34);
        tick();
        chk("t1_bubble_wr", 32'(bus_if.fifo_wr_en), 0);
        chk("t1_bubble_acc", 32'(bus_if.mem_access), 0);
        tick();
        chk("t1_next_addr", 32'(bus_if.mem_address), 32'h7fff9);
        chk("t1_npush", 32'(pushes.size()), 2);
        chk("t1_p0", 32'(pushes[0]), 32'h12);
        chk("t1_p1", 32'(pushes[1]), 32'h34);
        pushes.delete();

        // Redirect during FETCH, ack delayed 4 cycles
        load_new_ip = 1'b1;
        new_cs = 16'h0000;
        new_ip = 16'h0200;
        #1;
        chk("t4_freset", 32'(bus_if.fifo_reset), 1);
        chk("t4_wr_en", 32'(bus_if.fifo_wr_en), 0);
        tick();
        load_new_ip = 1'b0;
        chk("t4_freset_lo", 32'(bus_if.fifo_reset), 0);
        chk("t4_still_acc", 32'(bus_if.mem_access), 1);
        tick();
        tick();
        tick();
        chk("t4_addr_held", 32'(bus_if.mem_address), 32'h7fff9);
        ack(16'hdead);
        chk("t4_idle_acc", 32'(bus_if.mem_access), 0);
        chk("t4_idle_wr", 32'(bus_if.fifo_wr_en), 0);
        tick();
        chk("t4_new_acc", 32'(bus_if.mem_access), 1);
        chk("t4_new_addr", 32'(bus_if.mem_address), 32'h00100);
        chk("t4_npush", 32'(pushes.size()), 0);

        // Redirect coincident with ack, then odd IP 0000:0101
        bus_if.mem_ack = 1'b1;
        bus_if.mem_data = 16'h1111;
        load_new_ip = 1'b1;
        new_cs = 16'h0000;
        new_ip = 16'h0101;
        #1;
        chk("t6a_freset", 32'(bus_if.fifo_reset), 1);
        chk("t6a_wr_en", 32'(bus_if.fifo_wr_en), 0);
        tick();
        bus_if.mem_ack = 1'b0;
        load_new_ip = 1'b0;
        chk("t6a_idle", 32'(bus_if.mem_access), 0);
        tick();
        chk("t2_addr", 32'(bus_if.mem_address), 32'h00080);
        ack(16'hbbaa);
        chk("t2_wr_en", 32'(bus_if.fifo_wr_en), 1);
        chk("t2_wdata", 32'(bus_if.fifo_wr_data), 32'hbb);
        tick();
        chk("t2_done", 32'(bus_if.fifo_wr_en), 0);
        tick();
        chk("t2_next_addr", 32'(bus_if.mem_address), 32'h00081);
        chk("t2_npush", 32'(pushes.size()), 1);
        chk("t2_p0", 32'(pushes[0]), 32'hbb);
        pushes.delete();

        // FIFO full for 3 cycles after the first byte
        ack(16'h5566);
        chk("t3_wr0", 32'(bus_if.fifo_wr_data), 32'h66);
        tick();
        bus_if.fifo_full = 1'b1;
        #1;
        chk("t3_full_a", 32'(bus_if.fifo_wr_en), 0);
        chk("t3_hold", 32'(bus_if.fifo_wr_data), 32'h55);
        tick();
        chk("t3_full_b", 32'(bus_if.fifo_wr_en), 0);
        tick();
        chk("t3_full_c", 32'(bus_if.fifo_wr_en), 0);
        tick();
        bus_if.fifo_full = 1'b0;
        #1;
        chk("t3_resume", 32'(bus_if.fifo_wr_en), 1);
        chk("t3_wr1", 32'(bus_if.fifo_wr_data), 32'h55);
        tick();
        tick();
        chk("t3_next_addr", 32'(bus_if.mem_address), 32'h00082);
        chk("t3_npush", 32'(pushes.size()), 2);
        chk("t3_p0", 32'(pushes[0]), 32'h66);
        chk("t3_p1", 32'(pushes[1]), 32'h55);
        pushes.delete();

        // Redirect coincident with a DRAIN push
        ack(16'h7788);
        load_new_ip = 1'b1;
        new_cs = 16'h1000;
        new_ip = 16'hffff;
        #1;
        chk("t6b_wr_en", 32'(bus_if.fifo_wr_en), 0);
        chk("t6b_freset", 32'(bus_if.fifo_reset), 1);
        tick();
        load_new_ip = 1'b0;
        chk("t6b_idle_wr", 32'(bus_if.fifo_wr_en), 0);
        tick();
        chk("t6b_addr", 32'(bus_if.mem_address), 32'h0ffff);
        chk("t6b_npush", 32'(pushes.size()), 0);

        // IP FFFF: single high byte, IP wraps, CS kept
        ack(16'hcc99);
        chk("t5_wdata", 32'(bus_if.fifo_wr_data), 32'hcc);
        tick();
        chk("t5_done", 32'(bus_if.fifo_wr_en), 0);
        tick();
        chk("t5_acc", 32'(bus_if.mem_access), 1);
        chk("t5_addr", 32'(bus_if.mem_address), 32'h08000);
        chk("t5_npush", 32'(pushes.size()), 1);
        chk("t5_p0", 32'(pushes[0]), 32'hcc);

        // Reset mid-FETCH drops the request at once
        reset = 1'b1;
        #1;
        chk("rst2_access", 32'(bus_if.mem_access), 0);
        chk("rst2_addr", 32'(bus_if.mem_address), 32'h7fff8);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
